cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
// PURPOSE
//  Write-side controller for the cache data array: on a miss, fetches the 8-word block from
//  main memory (pipelined, fixed-latency) and writes each returned word into the array via
//  one-hot word enable, then commits the tag. Sits between the cache hit/miss logic and memory;
//  its busy output stalls the pipeline for the duration of the fill.
// PARAMETERS
//  ADDR_W    16  byte-address width
//  DATA_W    16  word width (one data-array word)
//  WORDS      8  words per cache block (power of two; word offset = log2(WORDS) bits)
// PORTS
//  clk               in   1       clock; all state updates on rising edge
//  rst               in   1       synchronous, active-high reset
//  miss_detected     in   1       level; cache lookup missed for miss_address
//  miss_address      in   ADDR_W  byte address that missed
//  memory_data       in   DATA_W  word returned by memory
//  memory_data_valid in   1       memory_data valid this cycle (returns in issue order)
//  fsm_busy          out  1       fill in progress; stall request
//  mem_read          out  1       memory read request this cycle
//  memory_address    out  ADDR_W  address of request issued this cycle
//  write_data_array  out  1       data array write strobe
//  word_enable       out  WORDS   one-hot word select for data-array write
//  fill_data         out  DATA_W  data for data-array write (= memory_data)
//  write_tag_array   out  1       tag/valid commit strobe, one cycle
// BEHAVIOUR
//  - States: IDLE, FILL. Reset -> IDLE, issue_cnt=0, recv_cnt=0, base=0; every output 0.
//  - IDLE & miss_detected: latch base = miss_address with low log2(WORDS)+1 bits cleared
//    (16-byte block), go FILL next edge. No output asserted in the accept cycle.
//  - fsm_busy = (state==FILL), registered.
//  - FILL issue: while issue_cnt<WORDS: mem_read=1, memory_address=base+2*issue_cnt, issue_cnt++
//    each cycle (one request/cycle, first request in first FILL cycle). After 8 issues mem_read=0,
//    memory_address=0.
//  - FILL receive (combinational from valid): memory_data_valid -> write_data_array=1,
//    word_enable=onehot(recv_cnt), fill_data=memory_data; recv_cnt++ at edge.
//  - Last word (valid & recv_cnt==WORDS-1): write_tag_array=1 same cycle; next edge -> IDLE,
//    counters cleared. Fill of 8 words with latency L spans L+8 FILL cycles.
//  - word_enable all-zero whenever write_data_array=0; never more than one bit set.
//  - memory_data_valid in IDLE: ignored, no writes. miss_detected during FILL: ignored.
//  - miss_detected held through completion cycle: not accepted until IDLE cycle after.
//  - Back-to-back misses: new miss accepted in first IDLE cycle; refetches fully.
//  - Stall in valid (gaps): receive simply waits; issue not throttled.
//  - rst mid-fill: next edge IDLE, counters 0, no further writes; late memory_data_valid
//    pulses from abandoned requests arrive in IDLE and are ignored.
//  - Counters width log2(WORDS)+1; address adds wrap modulo 2^ADDR_W (never within a block).
// STRUCTURE
//  - Shared cache package: state enum {IDLE,FILL}, WORDS, BLOCK_OFF_W, ADDR_W/DATA_W constants.
//  - One sub-module: onehot_dec (log2(WORDS)->WORDS decoder, enable-gated) for word_enable.
//  - State/counters/base in explicit dff registers with synchronous rst.
// TESTING
//  1 rst then miss at 0x1234 -> base 0x1230; mem_read 8 cycles, addrs 0x1230..0x123E step 2;
//    with latency 4, 8 writes word_enable 0x01..0x80 in order; tag strobe with 0x80; busy 12 cyc.
//  2 valid gaps (pattern 1,0,0,1,...) -> writes only on valid cycles, order intact, busy held
//    until 8th word, exactly one write_tag_array pulse.
//  3 miss held high across completion -> second fill starts one IDLE cycle later, same base.
//  4 rst asserted after 3rd word written, valid continues -> no writes/tag after rst, outputs 0,
//    busy 0 next cycle; subsequent miss at 0xFFF6 fetches 0xFFF0..0xFFFE correctly.
//  5 stray valid in IDLE and miss_detected toggled during FILL -> no writes in IDLE, base unchanged.
//  Assertions every cycle: $onehot0(word_enable); write_data_array==|word_enable; no mem_read in IDLE.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and types for the cache block-fill controller.
package cache_fill_fsm_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int WORDS       = 8;
    localparam int WORD_OFF_W  = $clog2(WORDS);
    localparam int BLOCK_OFF_W = WORD_OFF_W + 1;
    localparam int CNT_W       = WORD_OFF_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Byte offset within the block is cleared; words are two bytes wide.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] mask;
        mask = {ADDR_W{1'b1}} << BLOCK_OFF_W;
        return addr & mask;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_onehot_dec.sv
// Enable-gated binary to one-hot decoder used for the data-array word select.
module onehot_dec #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 1 << SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dec
);

    always_comb begin
        dec = '0;
        if (en) dec[sel] = 1'b1;
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Block-fill controller: issues one read per cycle for the missed block and
// writes each returned word into the data array, committing the tag on the last.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [WORDS-1:0]  word_enable,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array
);

    fill_state_t       state, state_next;
    logic [CNT_W-1:0]  issue_cnt, issue_next;
    logic [CNT_W-1:0]  recv_cnt, recv_next;
    logic [ADDR_W-1:0] base, base_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base      <= '0;
        end else begin
            state     <= state_next;
            issue_cnt <= issue_next;
            recv_cnt  <= recv_next;
            base      <= base_next;
        end
    end

    always_comb begin
        state_next       = state;
        issue_next       = issue_cnt;
        recv_next        = recv_cnt;
        base_next        = base;
        mem_read         = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_data        = '0;
        write_tag_array  = 1'b0;

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    base_next  = block_base(miss_address);
                    issue_next = '0;
                    recv_next  = '0;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (issue_cnt < CNT_W'(WORDS)) begin
                    mem_read       = 1'b1;
                    memory_address = base + ADDR_W'({issue_cnt, 1'b0});
                    issue_next     = issue_cnt + CNT_W'(1);
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_data        = memory_data;
                    recv_next        = recv_cnt + CNT_W'(1);
                    if (recv_cnt == CNT_W'(WORDS - 1)) begin
                        write_tag_array = 1'b1;
                        issue_next      = '0;
                        recv_next       = '0;
                        state_next      = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A fill being abandoned must not touch the arrays or memory in the reset cycle.
        if (rst) begin
            mem_read         = 1'b0;
            memory_address   = '0;
            write_data_array = 1'b0;
            fill_data        = '0;
            write_tag_array  = 1'b0;
        end
    end

    assign fsm_busy = (state == FILL);

    onehot_dec #(
        .SEL_W (WORD_OFF_W),
        .OUT_W (WORDS)
    ) u_word_dec (
        .en  (write_data_array),
        .sel (recv_cnt[WORD_OFF_W-1:0]),
        .dec (word_enable)
    );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency memory model and
// address/write scoreboards.
module tb_cache_fill_fsm;
    import cache_fill_fsm_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic [DATA_W-1:0] memory_data;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              mem_read;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [WORDS-1:0]  word_enable;
    logic [DATA_W-1:0] fill_data;
    logic              write_tag_array;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read          (mem_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_enable       (word_enable),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    typedef struct {
        int          ready;
        logic [15:0] data;
        int          idx;
        int          gen;
    } resp_t;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } wr_t;

    resp_t       pend[$];
    wr_t         exp_wr[$];
    logic [15:0] exp_addr[$];

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   gen = 0;
    int   latency = 4;
    bit   gaps = 1'b0;
    bit [3:0] gap_pat = 4'b1001;
    int   busy_cycles, tag_cnt, wr_cnt;
    bit   tag_seen;
    logic s_busy, s_mem_read, s_write, s_tag;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push_fill(input logic [15:0] miss);
        logic [15:0] b;
        b = miss & 16'hFFF0;
        for (int i = 0; i < 8; i++) exp_addr.push_back(b + 16'(2 * i));
    endtask

    task automatic tick();
        logic [15:0] a;
        resp_t       r;
        wr_t         w;
        @(negedge clk);
        s_busy     = fsm_busy;
        s_mem_read = mem_read;
        s_write    = write_data_array;
        s_tag      = write_tag_array;
        tag_seen   = 1'b0;
        chk("we_onehot0", 32'($onehot0(word_enable)), 1);
        chk("write_vs_we", write_data_array, |word_enable);
        if (!fsm_busy) chk("no_read_idle", mem_read, 0);
        if (fsm_busy) busy_cycles++;
        if (mem_read) begin
            if (exp_addr.size() == 0) chk("unexpected_read", mem_read, 0);
            else begin
                a = exp_addr.pop_front();
                chk("mem_addr", memory_address, a);
                pend.push_back('{cyc + latency, mem_word(a), int'(a[3:1]), gen});
            end
        end else chk("addr_zero_no_read", memory_address, 0);
        if (write_data_array) begin
            wr_cnt++;
            if (exp_wr.size() == 0) chk("unexpected_write", write_data_array, 0);
            else begin
                w = exp_wr.pop_front();
                chk("word_enable", word_enable, 32'(1) << w.idx);
                chk("fill_data", fill_data, w.data);
                chk("tag_strobe", write_tag_array, (w.idx == 7));
            end
        end else chk("tag_without_write", write_tag_array, 0);
        if (write_tag_array) begin
            tag_cnt++;
            tag_seen = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        memory_data_valid = 1'b0;
        memory_data       = '0;
        if (pend.size() > 0 && pend[0].ready <= cyc && (!gaps || gap_pat[cyc % 4])) begin
            r = pend.pop_front();
            memory_data_valid = 1'b1;
            memory_data       = r.data;
            if (r.gen == gen) exp_wr.push_back('{r.idx, r.data});
        end
    endtask

    task automatic wait_tag(input int bound);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!tag_seen && k < bound);
        chk("tag_timeout", tag_seen, 1);
    endtask

    task automatic start_miss(input logic [15:0] addr);
        push_fill(addr);
        miss_address  = addr;
        miss_detected = 1'b1;
        busy_cycles   = 0;
        tag_cnt       = 0;
        wr_cnt        = 0;
        tick();
        chk("accept_no_read", s_mem_read, 0);
        chk("accept_not_busy", s_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = '0;
        memory_data = '0;
        memory_data_valid = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset state, then a plain fill at latency 4
        tick();
        tick();
        chk("rst_busy", fsm_busy, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_addr", memory_address, 0);
        chk("rst_write", write_data_array, 0);
        chk("rst_we", word_enable, 0);
        chk("rst_tag", write_tag_array, 0);
        rst = 1'b0;
        tick();
        start_miss(16'h1234);
        miss_detected = 1'b0;
        tick();
        chk("t1_first_read", s_mem_read, 1);
        chk("t1_busy", s_busy, 1);
        wait_tag(40);
        tick();
        chk("t1_busy_cycles", busy_cycles, 12);
        chk("t1_tags", tag_cnt, 1);
        chk("t1_writes", wr_cnt, 8);
        chk("t1_idle_after", s_busy, 0);
        chk("t1_addr_left", exp_addr.size(), 0);

        // 2: gaps in the return stream
        gaps = 1'b1;
        start_miss(16'h2A7E);
        miss_detected = 1'b0;
        wait_tag(120);
        chk("t2_busy_at_tag", s_busy, 1);
        tick();
        chk("t2_tags", tag_cnt, 1);
        chk("t2_writes", wr_cnt, 8);
        chk("t2_busy_stretched", busy_cycles > 12, 1);
        chk("t2_idle_after", s_busy, 0);
        chk("t2_wr_left", exp_wr.size(), 0);
        gaps = 1'b0;

        // 3: miss held across completion
        push_fill(16'h0BEE);
        start_miss(16'h0BEE);
        wait_tag(40);
        tick();
        chk("t3_idle_gap_busy", s_busy, 0);
        chk("t3_idle_gap_read", s_mem_read, 0);
        tick();
        chk("t3_refill_busy", s_busy, 1);
        chk("t3_refill_read", s_mem_read, 1);
        miss_detected = 1'b0;
        wait_tag(40);
        tick();
        chk("t3_tags", tag_cnt, 2);
        chk("t3_writes", wr_cnt, 16);
        chk("t3_addr_left", exp_addr.size(), 0);

        // 4: reset after the third word, then a fill near the top of the address space
        start_miss(16'h3456);
        miss_detected = 1'b0;
        k = 0;
        while (wr_cnt < 3 && k < 40) begin
            tick();
            k++;
        end
        chk("t4_reached_3", wr_cnt, 3);
        rst = 1'b1;
        exp_addr.delete();
        exp_wr.delete();
        gen++;
        tag_cnt = 0;
        wr_cnt  = 0;
        tick();
        chk("t4_rst_write", s_write, 0);
        chk("t4_rst_tag", s_tag, 0);
        chk("t4_rst_read", s_mem_read, 0);
        rst = 1'b0;
        tick();
        chk("t4_busy_cleared", s_busy, 0);
        repeat (8) tick();
        chk("t4_late_writes", wr_cnt, 0);
        chk("t4_late_tags", tag_cnt, 0);
        start_miss(16'hFFF6);
        miss_detected = 1'b0;
        wait_tag(40);
        tick();
        chk("t4_tags", tag_cnt, 1);
        chk("t4_writes", wr_cnt, 8);
        chk("t4_addr_left", exp_addr.size(), 0);

        // 5: stray valid in IDLE, miss toggling during FILL
        for (int i = 0; i < 3; i++) pend.push_back('{cyc, 16'hDEAD, 0, -1});
        wr_cnt = 0;
        repeat (6) tick();
        chk("t5_stray_writes", wr_cnt, 0);
        chk("t5_stray_busy", s_busy, 0);
        start_miss(16'h4A5C);
        miss_detected = 1'b0;
        tick();
        miss_address  = 16'h7770;
        miss_detected = 1'b1;
        tick();
        miss_detected = 1'b0;
        tick();
        miss_detected = 1'b1;
        tick();
        miss_detected = 1'b0;
        wait_tag(40);
        tick();
        chk("t5_tags", tag_cnt, 1);
        chk("t5_writes", wr_cnt, 8);
        chk("t5_addr_left", exp_addr.size(), 0);
        chk("t5_idle_after", s_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
